cbus_arbiter: RTL and testbench

- Sits directly downstream of the instruction and data caches.
- Merges NUM_PORTS cbus_req_t request streams, from ICache/DCache and their uncached paths, into the single cbus_req_t/cbus_resp_t port to the memory interconnect.
- Grants one client per transaction and holds that grant for the whole burst, through the beat carrying cresp.last.
- Routes responses back only to the owning client; records protocol violations for debug.

---
 rtl/cbus_arbiter_if.sv | 48 ++++
 rtl/cbus_arbiter.sv | 141 ++++++++++++++
 tb/tb_cbus_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cbus_arbiter_if.sv
// Cache-bus request/response types and the bundle the arbiter sits on.
package cbus_pkg;

  typedef logic [3:0] mlen_t;

  // Burst length encodes beats-1, so a beat counter that started at 0
  // holds exactly this value when the final beat arrives.
  localparam mlen_t MLEN1  = 4'd0;
  localparam mlen_t MLEN2  = 4'd1;
  localparam mlen_t MLEN4  = 4'd3;
  localparam mlen_t MLEN8  = 4'd7;
  localparam mlen_t MLEN16 = 4'd15;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
    mlen_t       len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

// Client-side request/response arrays plus the single memory-side port.
// master: the arbiter. slave: whatever drives the clients and the memory.
interface cbus_arbiter_if
  import cbus_pkg::*;
#(
  parameter int NUM_PORTS = 2
);

  cbus_req_t  ireqs  [NUM_PORTS];
  cbus_resp_t iresps [NUM_PORTS];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  modport master (input ireqs, input oresp, output iresps, output oreq);
  modport slave  (output ireqs, output oresp, input iresps, input oreq);

endinterface

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: merges the cache-side request streams onto one memory port,
// holding each grant until the beat that carries last.
//
//   state | meaning
//   IDLE  | nothing granted; outputs quiet; arbitrate among valid clients
//   BUSY  | owner passed through to memory, responses routed back to owner
module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int POLICY    = 0,
  localparam int IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  cbus_arbiter_if.master   bus,
  output logic             busy,
  output logic [IDX_W-1:0] owner,
  output logic             err_len,
  output logic             err_drop
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] owner_q, owner_next;
  logic [IDX_W-1:0] rr_ptr, rr_next;
  logic [7:0]       beat, beat_next;
  logic             err_len_q, err_len_next;
  logic             err_drop_q, err_drop_next;

  logic [NUM_PORTS-1:0] req_valid;
  logic                 any_valid;
  logic [IDX_W-1:0]     winner;
  logic [IDX_W-1:0]     cand;
  cbus_req_t            own_req;

  // Winner selection; loops run downward so the preferred candidate is written last.
  always_comb begin
    req_valid = '0;
    any_valid = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_valid[i] = bus.ireqs[i].valid;
    end
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (POLICY == 1) begin
        cand = IDX_W'((int'(rr_ptr) + k) % NUM_PORTS);
      end else begin
        cand = IDX_W'(k);
      end
      if (req_valid[cand]) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
  end

  // Next-state, bookkeeping and bus routing.
  always_comb begin
    state_next    = state;
    owner_next    = owner_q;
    rr_next       = rr_ptr;
    beat_next     = beat;
    err_len_next  = err_len_q;
    err_drop_next = err_drop_q;
    own_req       = bus.ireqs[owner_q];
    bus.oreq      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      bus.iresps[i] = '0;
    end

    case (state)
      IDLE: begin
        if (any_valid) begin
          owner_next = winner;
          beat_next  = '0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // own_req.valid is 0 on a drop, so the pass-through already
        // presents an invalid request to memory that cycle.
        bus.oreq = own_req;
        if (!own_req.valid) begin
          err_drop_next = 1'b1;
          state_next    = IDLE;
        end else begin
          bus.iresps[owner_q] = bus.oresp;
          if (bus.oresp.ready) begin
            beat_next = beat + 8'd1;
            if (bus.oresp.last) begin
              if (beat != 8'(own_req.len)) begin
                err_len_next = 1'b1;
              end
              state_next = IDLE;
              if (POLICY == 1) begin
                rr_next = (int'(owner_q) == NUM_PORTS - 1) ? '0 : owner_q + 1'b1;
              end
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Keep both sides quiet while reset is held, even if a burst was in flight.
    if (reset) begin
      bus.oreq = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        bus.iresps[i] = '0;
      end
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner_q    <= '0;
      rr_ptr     <= '0;
      beat       <= '0;
      err_len_q  <= 1'b0;
      err_drop_q <= 1'b0;
    end else begin
      state      <= state_next;
      owner_q    <= owner_next;
      rr_ptr     <= rr_next;
      beat       <= beat_next;
      err_len_q  <= err_len_next;
      err_drop_q <= err_drop_next;
    end
  end

  assign busy     = (state == BUSY);
  assign owner    = owner_q;
  assign err_len  = err_len_q;
  assign err_drop = err_drop_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: one fixed-priority and one round-robin instance
// share the same client and memory stimulus; each is checked against its own
// transaction-level reference model.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int N = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cbus_req_t  reqs [N];
  cbus_resp_t mresp;

  cbus_arbiter_if #(.NUM_PORTS(N)) bus0 ();
  cbus_arbiter_if #(.NUM_PORTS(N)) bus1 ();

  logic       d_busy  [2];
  logic [0:0] d_owner [2];
  logic       d_elen  [2];
  logic       d_edrop [2];
  cbus_req_t  d_oreq  [2];
  cbus_resp_t d_iresp [2][N];

  cbus_arbiter #(.NUM_PORTS(N), .POLICY(0)) u_fixed (
    .clk(clk), .reset(reset), .bus(bus0.master),
    .busy(d_busy[0]), .owner(d_owner[0]), .err_len(d_elen[0]), .err_drop(d_edrop[0])
  );
  cbus_arbiter #(.NUM_PORTS(N), .POLICY(1)) u_rr (
    .clk(clk), .reset(reset), .bus(bus1.master),
    .busy(d_busy[1]), .owner(d_owner[1]), .err_len(d_elen[1]), .err_drop(d_edrop[1])
  );

  assign bus0.oresp = mresp;
  assign bus1.oresp = mresp;
  assign d_oreq[0]  = bus0.oreq;
  assign d_oreq[1]  = bus1.oreq;
  for (genvar i = 0; i < N; i++) begin : g_port
    assign bus0.ireqs[i]  = reqs[i];
    assign bus1.ireqs[i]  = reqs[i];
    assign d_iresp[0][i]  = bus0.iresps[i];
    assign d_iresp[1][i]  = bus1.iresps[i];
  end

  int n_tests = 0;
  int n_fail  = 0;
  mlen_t lens [5];

  // Reference model, one per policy (index 0 fixed, 1 round-robin).
  logic       m_busy  [2];
  int         m_owner [2];
  int         m_rr    [2];
  logic [7:0] m_beats [2];
  logic       m_elen  [2];
  logic       m_edrop [2];

  function automatic int pick(int p);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p == 0) ? k : (m_rr[p] + k) % N;
      if (reqs[idx].valid) return idx;
    end
    return -1;
  endfunction

  function automatic cbus_req_t exp_oreq(int p);
    if (m_busy[p] && !reset) return reqs[m_owner[p]];
    return '0;
  endfunction

  function automatic cbus_resp_t exp_iresp(int p, int i);
    if (m_busy[p] && !reset && i == m_owner[p] && reqs[i].valid) return mresp;
    return '0;
  endfunction

  function automatic cbus_req_t mk_req(logic wr, mlen_t len, logic [31:0] data);
    cbus_req_t r;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.addr     = $urandom;
    r.size     = 3'd2;
    r.strobe   = wr ? 4'hf : 4'h0;
    r.data     = data;
    r.len      = len;
    return r;
  endfunction

  // Advance the model on each clock from the inputs the bench is driving.
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (reset) begin
        m_busy[p] <= 1'b0; m_owner[p] <= 0; m_rr[p] <= 0;
        m_beats[p] <= '0; m_elen[p] <= 1'b0; m_edrop[p] <= 1'b0;
      end else if (!m_busy[p]) begin
        if (pick(p) >= 0) begin
          m_busy[p] <= 1'b1; m_owner[p] <= pick(p); m_beats[p] <= '0;
        end
      end else if (!reqs[m_owner[p]].valid) begin
        m_edrop[p] <= 1'b1; m_busy[p] <= 1'b0;
      end else if (mresp.ready) begin
        m_beats[p] <= m_beats[p] + 8'd1;
        if (mresp.last) begin
          if (m_beats[p] != 8'(reqs[m_owner[p]].len)) m_elen[p] <= 1'b1;
          m_busy[p] <= 1'b0;
          if (p == 1) m_rr[p] <= (m_owner[p] + 1) % N;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < N; i++) reqs[i] = '0;
    mresp = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    reqs[0] = mk_req(1'b0, MLEN4, $urandom);
    mresp = '{ready: 1'b1, last: 1'b0, data: 32'hdead_beef};
    repeat (2) begin
      @(negedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        n_tests++; if (d_oreq[p] !== '0) begin n_fail++; $display("FAIL reset_oreq p%0d got=%h exp=0", p, d_oreq[p]); end
        n_tests++; if (d_iresp[p][0] !== '0 || d_iresp[p][1] !== '0) begin n_fail++; $display("FAIL reset_iresps p%0d got=%h/%h exp=0", p, d_iresp[p][0], d_iresp[p][1]); end
      end
    end
    for (int p = 0; p < 2; p++) begin
      n_tests++; if (d_busy[p] !== 1'b0 || d_owner[p] !== 1'b0) begin n_fail++; $display("FAIL reset_state p%0d busy=%b owner=%0d exp 0/0", p, d_busy[p], d_owner[p]); end
      n_tests++; if (d_elen[p] !== 1'b0 || d_edrop[p] !== 1'b0) begin n_fail++; $display("FAIL reset_err p%0d err_len=%b err_drop=%b exp 0/0", p, d_elen[p], d_edrop[p]); end
    end
    @(negedge clk); reset = 1'b0; #1;
    for (int p = 0; p < 2; p++) begin
      n_tests++; if (d_busy[p] !== 1'b0 || d_oreq[p].valid !== 1'b0) begin n_fail++; $display("FAIL grant_latency_early p%0d busy=%b oreq.valid=%b exp 0/0", p, d_busy[p], d_oreq[p].valid); end
    end
    @(negedge clk); #1;
    for (int p = 0; p < 2; p++) begin
      n_tests++; if (d_busy[p] !== 1'b1 || d_owner[p] !== 1'b0) begin n_fail++; $display("FAIL grant_latency p%0d busy=%b owner=%0d exp 1/0", p, d_busy[p], d_owner[p]); end
      n_tests++; if (d_oreq[p] !== reqs[0]) begin n_fail++; $display("FAIL grant_oreq p%0d got=%h exp=%h", p, d_oreq[p], reqs[0]); end
    end
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    reqs[1] = mk_req(1'b0, MLEN16, $urandom); #1;
    for (int p = 0; p < 2; p++) begin
      n_tests++; if (d_oreq[p].valid !== 1'b0) begin n_fail++; $display("FAIL single_idle p%0d oreq.valid=%b exp=0", p, d_oreq[p].valid); end
    end
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      mresp = '{ready: 1'b1, last: (b == 15), data: $urandom}; #1;
      for (int p = 0; p < 2; p++) begin
        n_tests++; if (d_busy[p] !== 1'b1 || d_owner[p] !== 1'b1) begin n_fail++; $display("FAIL single_grant p%0d beat%0d busy=%b owner=%0d exp 1/1", p, b, d_busy[p], d_owner[p]); end
        n_tests++; if (d_oreq[p] !== reqs[1]) begin n_fail++; $display("FAIL single_oreq p%0d beat%0d got=%h exp=%h", p, b, d_oreq[p], reqs[1]); end
        n_tests++; if (d_iresp[p][1] !== mresp || d_iresp[p][0] !== '0) begin n_fail++; $display("FAIL single_resp p%0d beat%0d got=%h/%h exp=%h/0", p, b, d_iresp[p][1], d_iresp[p][0], mresp); end
      end
    end
    @(negedge clk);
    reqs[1] = '0; mresp = '0; #1;
    for (int p = 0; p < 2; p++) begin
      n_tests++; if (d_busy[p] !== 1'b0 || d_elen[p] !== 1'b0) begin n_fail++; $display("FAIL single_end p%0d busy=%b err_len=%b exp 0/0", p, d_busy[p], d_elen[p]); end
    end
  endtask

  task automatic test_priority();
    do_reset();
    @(negedge clk);
    reqs[0] = mk_req(1'b0, MLEN1, $urandom);
    reqs[1] = mk_req(1'b0, MLEN1, $urandom);
    mresp = '{ready: 1'b1, last: 1'b1, data: $urandom}; #1;
    @(negedge clk); #1;
    for (int p = 0; p < 2; p++) begin
      n_tests++; if (d_owner[p] !== 1'b0 || d_busy[p] !== 1'b1) begin n_fail++; $display("FAIL prio_first p%0d owner=%0d busy=%b exp 0/1", p, d_owner[p], d_busy[p]); end
      n_tests++; if (d_iresp[p][0] !== mresp || d_iresp[p][1] !== '0) begin n_fail++; $display("FAIL prio_resp0 p%0d got=%h/%h exp=%h/0", p, d_iresp[p][0], d_iresp[p][1], mresp); end
    end
    @(negedge clk);
    reqs[0] = '0; #1;
    for (int p = 0; p < 2; p++) begin
      n_tests++; if (d_busy[p] !== 1'b0 || d_iresp[p][1] !== '0) begin n_fail++; $display("FAIL prio_gap p%0d busy=%b iresp1=%h exp 0/0", p, d_busy[p], d_iresp[p][1]); end
    end
    @(negedge clk); #1;
    for (int p = 0; p < 2; p++) begin
      n_tests++; if (d_owner[p] !== 1'b1 || d_busy[p] !== 1'b1) begin n_fail++; $display("FAIL prio_second p%0d owner=%0d busy=%b exp 1/1", p, d_owner[p], d_busy[p]); end
      n_tests++; if (d_iresp[p][1] !== mresp || d_iresp[p][0] !== '0) begin n_fail++; $display("FAIL prio_resp1 p%0d got=%h/%h exp=%h/0", p, d_iresp[p][1], d_iresp[p][0], mresp); end
    end
    @(negedge clk);
    reqs[1] = '0; mresp = '0; #1;
    for (int p = 0; p < 2; p++) begin
      n_tests++; if (d_elen[p] !== 1'b0 || d_edrop[p] !== 1'b0) begin n_fail++; $display("FAIL prio_err p%0d err_len=%b err_drop=%b exp 0/0", p, d_elen[p], d_edrop[p]); end
    end
  endtask

  task automatic test_datapath();
    int beat = 0, cycles = 0, stall = 0;
    do_reset();
    @(negedge clk);
    reqs[0] = mk_req(1'b1, MLEN16, 32'h1);
    reqs[1] = mk_req(1'b0, MLEN1, $urandom);
    mresp = '0;
    while (beat < 16 && cycles < 200) begin
      @(negedge clk);
      cycles++;
      reqs[0].data = 32'(beat + 1);
      mresp.ready = 1'b1;
      if (stall > 0) begin
        stall--; mresp.ready = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        stall = 2; mresp.ready = 1'b0;
      end
      mresp.last = mresp.ready && (beat == 15);
      mresp.data = $urandom;
      #1;
      for (int p = 0; p < 2; p++) begin
        n_tests++; if (d_busy[p] !== 1'b1 || d_owner[p] !== 1'b0) begin n_fail++; $display("FAIL dp_grant p%0d cyc%0d busy=%b owner=%0d exp 1/0", p, cycles, d_busy[p], d_owner[p]); end
        n_tests++; if (d_oreq[p].data !== 32'(beat + 1) || d_oreq[p].is_write !== 1'b1 || d_oreq[p].valid !== 1'b1) begin n_fail++; $display("FAIL dp_data p%0d beat%0d got=%h exp=%h", p, beat, d_oreq[p].data, beat + 1); end
        n_tests++; if (d_iresp[p][0] !== mresp || d_iresp[p][1] !== '0) begin n_fail++; $display("FAIL dp_resp p%0d got=%h/%h exp=%h/0", p, d_iresp[p][0], d_iresp[p][1], mresp); end
      end
      if (mresp.ready) beat++;
    end
    n_tests++; if (beat != 16) begin n_fail++; $display("FAIL dp_timeout beats=%0d exp=16", beat); end
    @(negedge clk);
    reqs[0] = '0; mresp = '0; #1;
    for (int p = 0; p < 2; p++) begin
      n_tests++; if (d_busy[p] !== 1'b0 || d_elen[p] !== 1'b0) begin n_fail++; $display("FAIL dp_end p%0d busy=%b err_len=%b exp 0/0", p, d_busy[p], d_elen[p]); end
    end
  endtask

  task automatic test_err_len();
    do_reset();
    @(negedge clk);
    reqs[1] = mk_req(1'b0, MLEN16, $urandom);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      mresp = '{ready: 1'b1, last: (b == 7), data: $urandom}; #1;
      for (int p = 0; p < 2; p++) begin
        n_tests++; if (d_elen[p] !== 1'b0 || d_busy[p] !== 1'b1) begin n_fail++; $display("FAIL elen_early p%0d beat%0d err_len=%b busy=%b exp 0/1", p, b, d_elen[p], d_busy[p]); end
      end
    end
    @(negedge clk);
    reqs[1] = '0; mresp = '0; #1;
    for (int p = 0; p < 2; p++) begin
      n_tests++; if (d_elen[p] !== 1'b1 || d_edrop[p] !== 1'b0 || d_busy[p] !== 1'b0) begin n_fail++; $display("FAIL elen_set p%0d err_len=%b err_drop=%b busy=%b exp 1/0/0", p, d_elen[p], d_edrop[p], d_busy[p]); end
    end
  endtask

  task automatic test_err_drop();
    do_reset();
    @(negedge clk);
    reqs[0] = mk_req(1'b0, MLEN16, $urandom);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      mresp = '{ready: 1'b1, last: 1'b0, data: $urandom};
    end
    @(negedge clk);
    reqs[0].valid = 1'b0;
    mresp = '{ready: 1'b1, last: 1'b0, data: $urandom}; #1;
    for (int p = 0; p < 2; p++) begin
      n_tests++; if (d_oreq[p].valid !== 1'b0 || d_busy[p] !== 1'b1) begin n_fail++; $display("FAIL drop_cycle p%0d oreq.valid=%b busy=%b exp 0/1", p, d_oreq[p].valid, d_busy[p]); end
      n_tests++; if (d_iresp[p][0] !== '0 || d_edrop[p] !== 1'b0) begin n_fail++; $display("FAIL drop_resp p%0d iresp0=%h err_drop=%b exp 0/0", p, d_iresp[p][0], d_edrop[p]); end
    end
    @(negedge clk);
    reqs[0] = '0; mresp = '0; #1;
    for (int p = 0; p < 2; p++) begin
      n_tests++; if (d_busy[p] !== 1'b0 || d_edrop[p] !== 1'b1 || d_elen[p] !== 1'b0) begin n_fail++; $display("FAIL drop_after p%0d busy=%b err_drop=%b err_len=%b exp 0/1/0", p, d_busy[p], d_edrop[p], d_elen[p]); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    reqs[1] = mk_req(1'b0, MLEN16, $urandom);
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      mresp = '{ready: 1'b1, last: 1'b0, data: $urandom};
    end
    @(negedge clk);
    reset = 1'b1; #1;
    for (int p = 0; p < 2; p++) begin
      n_tests++; if (d_oreq[p] !== '0 || d_iresp[p][1] !== '0) begin n_fail++; $display("FAIL rstmid_during p%0d oreq=%h iresp1=%h exp 0/0", p, d_oreq[p], d_iresp[p][1]); end
      n_tests++; if (d_edrop[p] !== 1'b1) begin n_fail++; $display("FAIL rstmid_sticky p%0d err_drop=%b exp=1", p, d_edrop[p]); end
    end
    @(negedge clk);
    reset = 1'b0; #1;
    for (int p = 0; p < 2; p++) begin
      n_tests++; if (d_busy[p] !== 1'b0 || d_oreq[p].valid !== 1'b0 || d_owner[p] !== 1'b0) begin n_fail++; $display("FAIL rstmid_state p%0d busy=%b oreq.valid=%b owner=%0d exp 0/0/0", p, d_busy[p], d_oreq[p].valid, d_owner[p]); end
      n_tests++; if (d_elen[p] !== 1'b0 || d_edrop[p] !== 1'b0 || d_iresp[p][1] !== '0) begin n_fail++; $display("FAIL rstmid_err p%0d err_len=%b err_drop=%b iresp1=%h exp 0/0/0", p, d_elen[p], d_edrop[p], d_iresp[p][1]); end
    end
  endtask

  task automatic test_round_robin();
    int seq [2][4];
    int cnt [2];
    int exp_seq [2][4];
    exp_seq[0] = '{0, 0, 0, 0};
    exp_seq[1] = '{0, 1, 0, 1};
    cnt[0] = 0; cnt[1] = 0;
    do_reset();
    @(negedge clk);
    reqs[0] = mk_req(1'b0, MLEN1, $urandom);
    reqs[1] = mk_req(1'b0, MLEN1, $urandom);
    mresp = '{ready: 1'b1, last: 1'b1, data: $urandom};
    for (int c = 0; c < 40 && cnt[1] < 4; c++) begin
      @(negedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (d_busy[p] === 1'b1 && cnt[p] < 4) begin
          seq[p][cnt[p]] = int'(d_owner[p]);
          cnt[p]++;
        end
        n_tests++; if (d_busy[p] !== m_busy[p] || int'(d_owner[p]) != m_owner[p]) begin n_fail++; $display("FAIL rr_model p%0d busy=%b owner=%0d exp %b/%0d", p, d_busy[p], d_owner[p], m_busy[p], m_owner[p]); end
      end
    end
    for (int p = 0; p < 2; p++) begin
      n_tests++; if (cnt[p] != 4) begin n_fail++; $display("FAIL rr_count p%0d grants=%0d exp=4", p, cnt[p]); end
      else begin
        for (int g = 0; g < 4; g++) begin
          n_tests++; if (seq[p][g] != exp_seq[p][g]) begin n_fail++; $display("FAIL rr_seq p%0d grant%0d owner=%0d exp=%0d", p, g, seq[p][g], exp_seq[p][g]); end
        end
      end
    end
    @(negedge clk);
    reqs[0] = '0; reqs[1] = '0; mresp = '0;
  endtask

  task automatic test_random();
    logic fin [N];
    for (int i = 0; i < N; i++) fin[i] = 1'b0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (reqs[i].valid) begin
          if (fin[i] || $urandom_range(0, 99) == 0) reqs[i] = '0;
        end else if ($urandom_range(0, 3) == 0) begin
          reqs[i] = mk_req(1'($urandom_range(0, 1)), lens[$urandom_range(0, 4)], $urandom);
        end
      end
      mresp.ready = 1'($urandom_range(0, 1));
      mresp.data  = $urandom;
      mresp.last  = 1'b0;
      if (mresp.ready && m_busy[0]) begin
        if (m_beats[0] == 8'(reqs[m_owner[0]].len) || $urandom_range(0, 31) == 0) mresp.last = 1'b1;
      end
      #1;
      for (int p = 0; p < 2; p++) begin
        n_tests++; if (d_oreq[p] !== exp_oreq(p)) begin n_fail++; $display("FAIL rnd_oreq p%0d cyc%0d got=%h exp=%h", p, c, d_oreq[p], exp_oreq(p)); end
        for (int i = 0; i < N; i++) begin
          n_tests++; if (d_iresp[p][i] !== exp_iresp(p, i)) begin n_fail++; $display("FAIL rnd_iresp p%0d port%0d cyc%0d got=%h exp=%h", p, i, c, d_iresp[p][i], exp_iresp(p, i)); end
        end
        n_tests++; if (d_busy[p] !== m_busy[p] || int'(d_owner[p]) != m_owner[p]) begin n_fail++; $display("FAIL rnd_state p%0d cyc%0d busy=%b owner=%0d exp %b/%0d", p, c, d_busy[p], d_owner[p], m_busy[p], m_owner[p]); end
        n_tests++; if (d_elen[p] !== m_elen[p] || d_edrop[p] !== m_edrop[p]) begin n_fail++; $display("FAIL rnd_err p%0d cyc%0d err_len=%b err_drop=%b exp %b/%b", p, c, d_elen[p], d_edrop[p], m_elen[p], m_edrop[p]); end
      end
      for (int i = 0; i < N; i++) fin[i] = d_iresp[0][i].ready && d_iresp[0][i].last;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) reqs[i] = '0;
    mresp = '0;
    lens[0] = MLEN1; lens[1] = MLEN2; lens[2] = MLEN4; lens[3] = MLEN8; lens[4] = MLEN16;
    test_reset();
    test_single();
    test_priority();
    test_datapath();
    test_err_len();
    test_err_drop();
    test_reset_mid();
    test_round_robin();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
